// File: rtl/fifo_dwc_ff.sv
// Downsizing FIFO: stores IN_W-bit words and presents them OUT_W bits at a time, element 0
// first, with first-word-fall-through output and per-word element counts.
module fifo_dwc_ff #(
    parameter int DEPTH     = 8,
    parameter int IN_W      = 128,
    parameter int OUT_W     = 16,
    parameter int AF_THRESH = DEPTH - 1,
    localparam int NE       = IN_W / OUT_W,
    localparam int NE_W     = $clog2(NE + 1),
    localparam int LVL_W    = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [IN_W-1:0]  i_din,
    input  logic [NE_W-1:0]  i_nelem,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clearfifo,
    output logic             o_full,
    output logic             o_almost_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level,
    output logic             o_last,
    output logic [OUT_W-1:0] o_dout
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [IN_W-1:0]  mem_data  [DEPTH];
    logic [NE_W-1:0]  mem_nelem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic [NE_W-1:0]  rd_off;

    logic             empty;
    logic             full;
    logic             push_ok;
    logic             pop_ok;
    logic             at_last;
    logic             retire;
    logic [NE_W-1:0]  nelem_c;
    logic [NE_W-1:0]  head_nelem;
    logic [OUT_W-1:0] head_elem;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == LVL_W'(DEPTH));
    // Clear wins over push, so a clearing cycle never writes memory either.
    assign push_ok = i_push && !full && !i_clearfifo;
    assign pop_ok  = i_pop && !empty;

    // Zero or out-of-range element counts mean a full word.
    assign nelem_c = ((i_nelem == '0) || (i_nelem > NE_W'(NE))) ? NE_W'(NE) : i_nelem;

    assign head_nelem = mem_nelem[rd_ptr];
    assign at_last    = (rd_off == (head_nelem - NE_W'(1)));
    assign retire     = pop_ok && at_last;

    always_comb begin
        head_elem = '0;
        for (int i = 0; i < NE; i++) begin
            if (rd_off == NE_W'(i)) begin
                head_elem = mem_data[rd_ptr][i*OUT_W +: OUT_W];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_data[wr_ptr]  <= i_din;
            mem_nelem[wr_ptr] <= nelem_c;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rd_off <= '0;
        end else if (i_clearfifo) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rd_off <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                if (retire) begin
                    rd_off <= '0;
                    rd_ptr <= ptr_inc(rd_ptr);
                end else begin
                    rd_off <= rd_off + NE_W'(1);
                end
            end
            if (push_ok && !retire) begin
                count <= count + LVL_W'(1);
            end else if (!push_ok && retire) begin
                count <= count - LVL_W'(1);
            end
        end
    end

    assign o_empty       = empty;
    assign o_full        = full;
    assign o_level       = count;
    assign o_almost_full = (int'(count) >= AF_THRESH);
    assign o_last        = !empty && at_last;
    assign o_dout        = empty ? '0 : head_elem;

endmodule

// File: tb/tb_fifo_dwc_ff.sv
// Scoreboard bench for fifo_dwc_ff: a flat queue of expected elements plus a word count,
// checked by a negedge monitor against every output each cycle.
module tb_fifo_dwc_ff;

    localparam int DEPTH     = 8;
    localparam int IN_W      = 128;
    localparam int OUT_W     = 16;
    localparam int AF_THRESH = DEPTH - 1;
    localparam int NE        = IN_W / OUT_W;
    localparam int NE_W      = $clog2(NE + 1);
    localparam int LVL_W     = $clog2(DEPTH + 1);

    logic             i_clk = 1'b0;
    logic             i_rstn = 1'b0;
    logic [IN_W-1:0]  i_din = '0;
    logic [NE_W-1:0]  i_nelem = '0;
    logic             i_push = 1'b0;
    logic             i_pop = 1'b0;
    logic             i_clearfifo = 1'b0;
    logic             o_full;
    logic             o_almost_full;
    logic             o_empty;
    logic [LVL_W-1:0] o_level;
    logic             o_last;
    logic [OUT_W-1:0] o_dout;

    fifo_dwc_ff #(
        .DEPTH     (DEPTH),
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .AF_THRESH (AF_THRESH)
    ) dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_din         (i_din),
        .i_nelem       (i_nelem),
        .i_push        (i_push),
        .i_pop         (i_pop),
        .i_clearfifo   (i_clearfifo),
        .o_full        (o_full),
        .o_almost_full (o_almost_full),
        .o_empty       (o_empty),
        .o_level       (o_level),
        .o_last        (o_last),
        .o_dout        (o_dout)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [OUT_W-1:0] elem;
        logic             last;
    } exp_t;

    exp_t exp_q[$];
    int   mwords   = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, req);
        end
    endtask

    task automatic model_flush();
        exp_q.delete();
        mwords = 0;
    endtask

    task automatic model_push(input logic [IN_W-1:0] din, input int ne);
        int n;
        n = (ne == 0 || ne > NE) ? NE : ne;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{elem: din[i*OUT_W +: OUT_W], last: (i == n - 1)});
        end
        mwords++;
    endtask

    // Monitor: compare outputs with the model, then retire whatever the coming edge pops.
    always @(negedge i_clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            check("dout", o_dout, exp_q[0].elem);
            check("last", o_last, exp_q[0].last);
        end else begin
            check("dout_empty", o_dout, 0);
            check("last_empty", o_last, 0);
        end
        check("level", o_level, mwords);
        check("empty", o_empty, mwords == 0);
        check("full", o_full, mwords == DEPTH);
        check("almost_full", o_almost_full, mwords >= AF_THRESH);
        if (i_rstn && !i_clearfifo && i_pop && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.last) mwords--;
        end
    end

    // One clock of stimulus; the push lands in the model after the monitor has run.
    task automatic step(input logic push, input logic pop, input logic clr,
                        input logic [IN_W-1:0] din, input int ne);
        logic push_acc;
        @(posedge i_clk);
        #1;
        i_push      = push;
        i_pop       = pop;
        i_clearfifo = clr;
        i_din       = din;
        i_nelem     = NE_W'(ne);
        push_acc    = push && !clr && (mwords < DEPTH);
        @(negedge i_clk);
        #2;
        if (clr) model_flush();
        else if (push_acc) model_push(din, ne);
    endtask

    task automatic reset_mid();
        @(posedge i_clk);
        #1;
        i_push      = 1'b0;
        i_pop       = 1'b0;
        i_clearfifo = 1'b0;
        #2;
        i_rstn = 1'b0;
        model_flush();
        #1;
        check("rst_level", o_level, 0);
        check("rst_empty", o_empty, 1);
        check("rst_dout", o_dout, 0);
        check("rst_last", o_last, 0);
        @(negedge i_clk);
        #2;
        i_rstn = 1'b1;
    endtask

    function automatic logic [IN_W-1:0] rand_word();
        logic [IN_W-1:0] w;
        for (int i = 0; i < IN_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    initial begin
        logic [IN_W-1:0] ramp;
        int pp;
        int qp;
        for (int i = 0; i < NE; i++) ramp[i*OUT_W +: OUT_W] = OUT_W'(i);
        #12;
        i_rstn = 1'b1;

        // Ramp word, full width, drained one element per cycle plus one extra pop.
        step(1, 0, 0, ramp, 0);
        for (int i = 0; i < NE + 1; i++) step(0, 1, 0, '0, 0);

        // Fill past full, then drain and pop while empty.
        for (int i = 0; i < DEPTH + 1; i++) step(1, 0, 0, rand_word(), 0);
        for (int i = 0; i < DEPTH * NE + 3; i++) step(0, 1, 0, '0, 0);

        // Partial words and an oversized element count.
        step(1, 0, 0, ramp, 3);
        step(1, 0, 0, rand_word(), 12);
        step(1, 0, 0, rand_word(), 1);
        for (int i = 0; i < 14; i++) step(0, 1, 0, '0, 0);

        // Clear mid-word with a simultaneous push, then restart.
        step(1, 0, 0, ramp, 0);
        step(1, 0, 0, rand_word(), 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, '0, 0);
        step(1, 1, 1, rand_word(), 0);
        step(1, 0, 0, ramp, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, '0, 0);

        // Same with an asynchronous reset.
        step(1, 0, 0, ramp, 0);
        for (int i = 0; i < 2; i++) step(0, 1, 0, '0, 0);
        reset_mid();
        step(1, 0, 0, ramp, 5);
        for (int i = 0; i < 6; i++) step(0, 1, 0, '0, 0);

        // Random traffic: fill-heavy, drain-heavy and balanced phases.
        for (int c = 0; c < 1800; c++) begin
            case (c / 600)
                0:       begin pp = 80; qp = 30; end
                1:       begin pp = 25; qp = 85; end
                default: begin pp = 50; qp = 60; end
            endcase
            step($urandom_range(0, 99) < pp, $urandom_range(0, 99) < qp,
                 $urandom_range(0, 127) == 0, rand_word(), int'($urandom_range(0, 15)));
            if (c == 900) reset_mid();
        end
        step(0, 0, 0, '0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
